// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_fsm
//  Brief    : Multi-cycle MIPS control sequencer with memory wait/timeout
//             handling and a sticky error trap.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       fault,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEXEC = 4'd7,
        S_RTWB   = 4'd8,
        S_BEQ    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_ERROR  = 4'd15
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    localparam logic [TO_W-1:0] c_cnt_max = {TO_W{1'b1}};
    localparam logic [TO_W-1:0] c_timeout = TIMEOUT[TO_W-1:0];

    state_t          r_state;
    state_t          w_next_state;
    logic [TO_W-1:0] r_wait_cnt;
    logic            w_in_wait;
    logic            w_timed_out;

    // Branch resolution happens in the datapath; zero is only passed through.
    logic w_unused_zero;
    assign w_unused_zero = zero;

    assign w_in_wait   = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                         (r_state == S_MEMWR);
    assign w_timed_out = (r_wait_cnt == c_timeout) && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Counter restarts on every entry to a wait state and on each completed transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (!w_in_wait || mem_ready || (w_next_state != r_state)) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != c_cnt_max) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   w_next_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready)        w_next_state = S_DECODE;
                else if (w_timed_out) w_next_state = S_ERROR;
            end
            S_DECODE: begin
                case (opcode)
                    c_op_rtype:        w_next_state = S_RTEXEC;
                    c_op_lw, c_op_sw:  w_next_state = S_MEMADR;
                    c_op_beq:          w_next_state = S_BEQ;
                    c_op_addi:         w_next_state = S_ADDIEX;
                    c_op_j:            w_next_state = S_JUMP;
                    default:           w_next_state = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                if (opcode == c_op_lw)      w_next_state = S_MEMRD;
                else if (opcode == c_op_sw) w_next_state = S_MEMWR;
                else                        w_next_state = S_ERROR;
            end
            S_MEMRD: begin
                if (mem_ready)        w_next_state = S_MEMWB;
                else if (w_timed_out) w_next_state = S_ERROR;
            end
            S_MEMWR: begin
                if (mem_ready)        w_next_state = S_FETCH;
                else if (w_timed_out) w_next_state = S_ERROR;
            end
            S_MEMWB:  w_next_state = S_FETCH;
            S_RTEXEC: w_next_state = S_RTWB;
            S_RTWB:   w_next_state = S_FETCH;
            S_BEQ:    w_next_state = S_FETCH;
            S_ADDIEX: w_next_state = S_ADDIWB;
            S_ADDIWB: w_next_state = S_FETCH;
            S_JUMP:   w_next_state = S_FETCH;
            S_ERROR:  w_next_state = S_ERROR;
            default:  w_next_state = S_ERROR;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        fault         = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_RTEXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RTWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ERROR: begin
                fault = 1'b1;
            end
            default: begin
                fault = 1'b0;
            end
        endcase
    end

    assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control_fsm
//  Brief    : Scoreboard bench for the multi-cycle control sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, fault;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_dbg;

    multicycle_control_fsm #(.TIMEOUT(15), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .fault(fault), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, fault}
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy);
        logic pcw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, flt;
        logic [1:0] sb2, aop, psrc;
        pcw = 0; pwc = 0; iod = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0;
        rdst = 0; rw = 0; sa = 0; flt = 0; sb2 = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            4'd1:  begin mrd = 1; sb2 = 2'b01; irw = rdy; pcw = rdy; end
            4'd2:  sb2 = 2'b11;
            4'd3:  begin sa = 1; sb2 = 2'b10; end
            4'd4:  begin mrd = 1; iod = 1; end
            4'd5:  begin m2r = 1; rw = 1; end
            4'd6:  begin mwr = 1; iod = 1; end
            4'd7:  begin sa = 1; aop = 2'b10; end
            4'd8:  begin rdst = 1; rw = 1; end
            4'd9:  begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            4'd10: begin sa = 1; sb2 = 2'b10; end
            4'd11: rw = 1;
            4'd12: begin pcw = 1; psrc = 2'b10; end
            4'd15: flt = 1;
            default: ;
        endcase
        return {pcw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, sb2, aop, psrc, flt};
    endfunction

    // One clock of stimulus with the state the DUT must sit in during that clock.
    task automatic step(input logic [5:0] op, input logic rdy, input logic z,
                        input logic [3:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        opcode    = op;
        mem_ready = rdy;
        zero      = z;
        e.st      = st;
        e.ctrl    = exp_ctrl(st, rdy);
        sb.push_back(e);
    endtask

    task automatic set_rst(input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = r;
        mem_ready = 1'b0;
        e.st      = 4'd0;
        e.ctrl    = '0;
        sb.push_back(e);
    endtask

    // Monitor: the DUT presents a control word every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        logic [16:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                       pc_source, fault};
                n_checks++;
                if (state_dbg === e.st) n_pass++;
                else $display("FAIL state t=%0t actual=%0d required=%0d", $time, state_dbg, e.st);
                n_checks++;
                if (act === e.ctrl) n_pass++;
                else $display("FAIL ctrl state=%0d t=%0t actual=%b required=%b",
                              e.st, $time, act, e.ctrl);
            end
        end
    end

    initial begin
        rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        set_rst(1'b0);
        set_rst(1'b0);
        set_rst(1'b1);
        // R-type
        step(6'b000000, 1, 0, 4'd1);
        step(6'b000000, 1, 0, 4'd2);
        step(6'b000000, 1, 0, 4'd7);
        step(6'b000000, 1, 0, 4'd8);
        // LW with three wait cycles in MEMRD
        step(6'b100011, 1, 0, 4'd1);
        step(6'b100011, 1, 0, 4'd2);
        step(6'b100011, 0, 0, 4'd3);
        step(6'b100011, 0, 0, 4'd4);
        step(6'b100011, 0, 0, 4'd4);
        step(6'b100011, 0, 0, 4'd4);
        step(6'b100011, 1, 0, 4'd4);
        step(6'b100011, 0, 0, 4'd5);
        // SW with one wait cycle
        step(6'b101011, 1, 0, 4'd1);
        step(6'b101011, 1, 0, 4'd2);
        step(6'b101011, 0, 0, 4'd3);
        step(6'b101011, 0, 0, 4'd6);
        step(6'b101011, 1, 0, 4'd6);
        // BEQ taken, then not taken
        step(6'b000100, 1, 1, 4'd1);
        step(6'b000100, 1, 1, 4'd2);
        step(6'b000100, 1, 1, 4'd9);
        step(6'b000100, 1, 0, 4'd1);
        step(6'b000100, 1, 0, 4'd2);
        step(6'b000100, 1, 0, 4'd9);
        // ADDI
        step(6'b001000, 1, 0, 4'd1);
        step(6'b001000, 1, 0, 4'd2);
        step(6'b001000, 1, 0, 4'd10);
        step(6'b001000, 1, 0, 4'd11);
        // J
        step(6'b000010, 1, 0, 4'd1);
        step(6'b000010, 1, 0, 4'd2);
        step(6'b000010, 1, 0, 4'd12);
        // FETCH: ready arrives on the 16th waiting cycle, transfer completes
        for (int i = 0; i < 15; i++) step(6'b000000, 0, 0, 4'd1);
        step(6'b000000, 1, 0, 4'd1);
        step(6'b000000, 1, 0, 4'd2);
        step(6'b000000, 1, 0, 4'd7);
        step(6'b000000, 1, 0, 4'd8);
        // Reset mid-LW while waiting in MEMRD
        step(6'b100011, 1, 0, 4'd1);
        step(6'b100011, 1, 0, 4'd2);
        step(6'b100011, 0, 0, 4'd3);
        step(6'b100011, 0, 0, 4'd4);
        set_rst(1'b0);
        set_rst(1'b1);
        // FETCH timeout: 16 waiting cycles then ERROR, which absorbs
        for (int i = 0; i < 16; i++) step(6'b000000, 0, 0, 4'd1);
        step(6'b000000, 1, 0, 4'd15);
        step(6'b000000, 1, 0, 4'd15);
        set_rst(1'b0);
        set_rst(1'b1);
        // Illegal opcode
        step(6'b111111, 1, 0, 4'd1);
        step(6'b111111, 1, 0, 4'd2);
        step(6'b111111, 1, 0, 4'd15);
        step(6'b000000, 1, 0, 4'd15);
        step(6'b100011, 0, 0, 4'd15);
        set_rst(1'b0);
        set_rst(1'b1);
        step(6'b000000, 1, 0, 4'd1);
        step(6'b000000, 1, 0, 4'd2);
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain actual=%0d pending required=0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle MIPS control sequencer for the shared-memory, single-ALU datapath.
- Replaces per-instruction combinational decode with a state machine that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Decodes the same opcode set as the single-cycle control, plus ADDI and J.
- Adds a memory-ready wait handshake with timeout, and an error trap.

Parameters:
- TIMEOUT, 15: maximum wait cycles for mem_ready before trapping.
- TO_W, 4: width of the wait counter; must hold TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instr[31:26] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if zero=1 (BEQ)
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  writeback select: 1=MDR, 0=ALUOut
- reg_dst  output  1  destination select: 1=rd, 0=rt
- reg_write  output  1  register file write
- alu_src_a  output  1  0=PC, 1=A
- alu_src_b  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
- alu_op  output  2  00=add, 01=sub, 10=funct decode
- pc_source  output  2  00=ALU, 01=ALUOut, 10=jump target
- fault  output  1  sticky error (illegal opcode or memory timeout)
- state_dbg  output  4  current state encoding

Behaviour:
- State register is 4 bits. Encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
  - RTEXEC=7, RTWB=8, BEQ=9, ADDIEX=10, ADDIWB=11, JUMP=12, ERROR=15
- Async reset (rst_n=0):
  - state=IDLE, wait counter=0, fault=0.
  - All control outputs are 0 while in IDLE.
- Outputs are decoded from the state. Exception: FETCH qualifies ir_write and pc_write with mem_ready.
- Unlisted outputs are 0 in every state.
- IDLE: → FETCH on the next clock. Provides one dead cycle after reset release.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - mem_ready=1 → DECODE; otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 000000 → RTEXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BEQ
  - 001000 → ADDIEX
  - 000010 → JUMP
  - anything else → ERROR
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW → MEMRD, SW → MEMWR.
- MEMRD: mem_read=1, i_or_d=1. mem_ready → MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. → FETCH.
- MEMWR: mem_write=1, i_or_d=1. mem_ready → FETCH.
- RTEXEC: alu_src_a=1, alu_src_b=00, alu_op=10. → RTWB.
- RTWB: reg_dst=1, mem_to_reg=0, reg_write=1. → FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. → FETCH.
  - The datapath forms pc_en = pc_write | (pc_write_cond & zero). This block does not gate zero.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. → ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. → FETCH.
- JUMP: pc_write=1, pc_source=10. → FETCH.
- ERROR:
  - All strobes are 0; fault=1.
  - Absorbing: only rst_n leaves ERROR.
- Instruction latency without waits: R-type 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3 cycles.
- Wait counter (FETCH, MEMRD, MEMWR only):
  - Clears on entry to a wait state and on mem_ready=1.
  - Increments each cycle mem_ready=0.
  - When counter==TIMEOUT and mem_ready=0 → ERROR next cycle.
  - mem_ready=1 in the same cycle as counter==TIMEOUT: the transfer completes normally (ready wins).
  - Counter saturates and never wraps.
- mem_read/mem_write stay asserted, unchanged, for every wait cycle. There is no strobe glitch between wait cycles.
- Reset asserted mid-instruction: immediate return to IDLE, all outputs 0. No partial writeback completes after reset.
- opcode is sampled only in DECODE and MEMADR. The IR is stable there because ir_write=0.

Test Plan:
- Reset, then opcode=000000 with mem_ready=1 held → state_dbg 0,1,2,7,8,1. reg_write=1 and reg_dst=1 only in state 8.
- LW (100011) with mem_ready low 3 cycles in MEMRD → MEMRD lasts 4 cycles with mem_read=1, i_or_d=1 throughout. MEMWB has mem_to_reg=1 and reg_write=1.
- BEQ with zero=1, then with zero=0 → pc_write_cond=1, pc_source=01 for exactly one cycle in both cases. No reg_write or mem_write.
- J (000010) → 3-cycle instruction. JUMP state has pc_write=1, pc_source=10.
- opcode=111111 in DECODE → ERROR, fault=1, all strobes 0 until rst_n pulse, then IDLE with fault=0.
- mem_ready held 0 in FETCH → ERROR after TIMEOUT+1=16 waiting cycles. mem_ready=1 arriving on the 16th cycle → DECODE, no fault.
